// File: rtl/servo_pulse_decoder_if.sv
// servo_pulse_decoder_if: servo input line plus decoded position/strobe/status outputs (master drives the pin, slave is the decoder)
interface servo_pulse_decoder_if;
  logic       servo_pulse;
  logic [7:0] pos;
  logic       valid;
  logic       err;
  logic       lost;
  modport master (output servo_pulse, input pos, valid, err, lost);
  modport slave (input servo_pulse, output pos, valid, err, lost);
endinterface

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: measures servo pulse high time and recovers position; ports clk, rst (async high), bus.slave (servo_pulse in; pos, valid, err, lost out)
module servo_pulse_decoder #(
  parameter int MIN_CYCLES     = 25000,
  parameter int STEP_CYCLES    = 98,
  parameter int MAX_CYCLES     = 62500,
  parameter int TIMEOUT_CYCLES = 625000
) (
  input logic                  clk,
  input logic                  rst,
  servo_pulse_decoder_if.slave bus
);
  localparam int SW = $clog2(STEP_CYCLES);
  typedef enum logic [1:0] {IDLE, HIGH_MIN, HIGH_POS, HIGH_OVER} state_t;
  state_t          state, state_n;
  logic            s1, s2, s3;
  logic            rise, fall;
  logic [19:0]     width, tcnt;
  logic [SW-1:0]   step;
  logic [7:0]      acc, pos_r;
  logic            valid_d, err_d, valid_r, err_r, lost_r;
  logic            wrap;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign wrap = step == SW'(STEP_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Leaving HIGH_MIN one count early means a fall in HIGH_MIN is always too short,
  // and a fall in HIGH_POS is always in range (HIGH_OVER is entered at exactly MAX).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rise ? HIGH_MIN : IDLE;
      HIGH_MIN:  state_n = fall ? IDLE : (width == 20'(MIN_CYCLES - 1) ? HIGH_POS : HIGH_MIN);
      HIGH_POS:  state_n = fall ? IDLE : (width == 20'(MAX_CYCLES) ? HIGH_OVER : HIGH_POS);
      default:   state_n = fall ? IDLE : HIGH_OVER;
    endcase
  end
  always_comb begin
    valid_d = fall && state == HIGH_POS;
    err_d   = fall && (state == HIGH_MIN || state == HIGH_OVER);
  end
  // width counts the rise cycle too, so on the fall cycle it equals the pulse width;
  // in HIGH_POS step/acc hold (width-MIN) mod/div STEP.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      width   <= '0;
      tcnt    <= '0;
      step    <= '0;
      acc     <= '0;
      pos_r   <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      lost_r  <= 1'b0;
    end else begin
      s1      <= bus.servo_pulse;
      s2      <= s1;
      s3      <= s2;
      width   <= state == IDLE ? 20'd1 : (&width ? width : width + 20'd1);
      tcnt    <= rise ? '0 : (&tcnt ? tcnt : tcnt + 20'd1);
      step    <= state == HIGH_POS && !wrap ? step + SW'(1) : '0;
      acc     <= state != HIGH_POS ? '0 : (wrap && !(&acc) ? acc + 8'd1 : acc);
      pos_r   <= valid_d ? acc : pos_r;
      valid_r <= valid_d;
      err_r   <= err_d;
      lost_r  <= !valid_d && (lost_r || tcnt >= 20'(TIMEOUT_CYCLES));
    end
  assign bus.pos   = pos_r;
  assign bus.valid = valid_r;
  assign bus.err   = err_r;
  assign bus.lost  = lost_r;
endmodule
